// File: rtl/serial_median_filter.sv
// Bit-serial 3-tap median (majority) filter: collects a WIDTH-bit word LSB first,
// filters it in one cycle and holds the result until downstream takes it.
module serial_median_filter #(
    parameter int unsigned WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bitIn,
    input  logic             bitValid,
    output logic             bitReady,
    input  logic             frameStart,
    output logic [WIDTH-1:0] filteredVal,
    output logic             wordValid,
    input  logic             wordReady,
    output logic             busy
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastIdx = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StCollect,
        StFilter,
        StHold
    } state_e;

    state_e           state_q;
    logic [CntW-1:0]  bit_cnt_q;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] x_d;
    logic [WIDTH-1:0] filt_q;
    logic [WIDTH-1:0] filt_d;
    logic             bit_ready_q;
    logic             word_valid_q;
    logic             busy_q;
    logic             bit_accept;

    // bit_ready_q is high exactly when the FSM sits in StCollect.
    assign bit_accept = bitValid && bit_ready_q;

    always_comb begin
        x_d = x_q;
        if (frameStart) begin
            x_d    = '0;
            x_d[0] = bitIn;
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (bit_cnt_q == CntW'(i)) begin
                    x_d[i] = bitIn;
                end
            end
        end
    end

    // MSB is forced low; the two edge taps degenerate to an AND of their two neighbours.
    always_comb begin
        filt_d          = '0;
        filt_d[WIDTH-2] = x_q[WIDTH-2] & x_q[WIDTH-3];
        for (int i = 1; i <= int'(WIDTH) - 3; i++) begin
            filt_d[i] = (x_q[i+1] & x_q[i]) | (x_q[i+1] & x_q[i-1]) | (x_q[i] & x_q[i-1]);
        end
        filt_d[0] = x_q[1] & x_q[0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StCollect;
            bit_cnt_q    <= '0;
            x_q          <= '0;
            filt_q       <= '0;
            bit_ready_q  <= 1'b1;
            word_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            unique case (state_q)
                StCollect: begin
                    if (bit_accept) begin
                        x_q    <= x_d;
                        busy_q <= 1'b1;
                        if (frameStart) begin
                            bit_cnt_q <= CntW'(1);
                        end else if (bit_cnt_q == LastIdx) begin
                            bit_cnt_q   <= '0;
                            bit_ready_q <= 1'b0;
                            state_q     <= StFilter;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CntW'(1);
                        end
                    end
                end
                StFilter: begin
                    filt_q       <= filt_d;
                    word_valid_q <= 1'b1;
                    state_q      <= StHold;
                end
                StHold: begin
                    if (wordReady) begin
                        word_valid_q <= 1'b0;
                        bit_ready_q  <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= StCollect;
                    end
                end
                default: begin
                    state_q      <= StCollect;
                    bit_cnt_q    <= '0;
                    bit_ready_q  <= 1'b1;
                    word_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign bitReady    = bit_ready_q;
    assign wordValid   = word_valid_q;
    assign busy        = busy_q;
    assign filteredVal = filt_q;

endmodule

// File: tb/tb_serial_median_filter.sv
// Self-checking bench for serial_median_filter: directed vectors, stalls, framing,
// reset cases and randomized words against a behavioural filter model.
module tb_serial_median_filter;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         reset;
    logic         bitIn;
    logic         bitValid;
    logic         bitReady;
    logic         frameStart;
    logic [W-1:0] filteredVal;
    logic         wordValid;
    logic         wordReady;
    logic         busy;

    int errors = 0;
    int checks = 0;
    int wv_rises = 0;
    logic wv_prev = 1'b0;

    always #5 clk = ~clk;

    serial_median_filter #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .bitIn      (bitIn),
        .bitValid   (bitValid),
        .bitReady   (bitReady),
        .frameStart (frameStart),
        .filteredVal(filteredVal),
        .wordValid  (wordValid),
        .wordReady  (wordReady),
        .busy       (busy)
    );

    always @(posedge clk) begin
        wv_prev <= wordValid;
        if (wordValid && !wv_prev) wv_rises <= wv_rises + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: each output bit is the majority of its neighbourhood, with the
    // edge rules written out as counts of ones.
    function automatic logic [W-1:0] ref_filter(input logic [W-1:0] w);
        int b[W];
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) b[i] = w[i] ? 1 : 0;
        for (int i = 0; i < W; i++) begin
            if (i == W - 1) r[i] = 1'b0;
            else if (i == W - 2) r[i] = (b[i] + b[i-1] == 2);
            else if (i == 0) r[i] = (b[1] + b[0] == 2);
            else r[i] = (b[i+1] + b[i] + b[i-1] >= 2);
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic fs);
        int n;
        n = 0;
        bitValid = 1'b0;
        while (!bitReady && n < 20) begin
            tick();
            n++;
        end
        if (!bitReady) begin
            errors++;
            checks++;
            $display("FAIL send_bit_ready: bitReady=%b required 1", bitReady);
        end
        bitIn = b;
        frameStart = fs;
        bitValid = 1'b1;
        tick();
        bitValid = 1'b0;
        frameStart = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] w, input logic fs_first);
        for (int i = 0; i < W; i++) send_bit(w[i], fs_first && (i == 0));
    endtask

    // Called in the cycle after the last bit was accepted; lat counts from that bit.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!wordValid && lat < 30) begin
            tick();
            lat++;
        end
    endtask

    task automatic consume();
        wordReady = 1'b1;
        tick();
        wordReady = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bitValid = 1'b1;
        bitIn = 1'b1;
        frameStart = 1'b1;
        wordReady = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        bitValid = 1'b0;
        frameStart = 1'b0;
        wordReady = 1'b0;
        checks++;
        if (wordValid !== 1'b0) begin
            errors++; $display("FAIL reset_wordValid: got %b want 0", wordValid);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b want 0", busy);
        end
        checks++;
        if (bitReady !== 1'b1) begin
            errors++; $display("FAIL reset_bitReady: got %b want 1", bitReady);
        end
        checks++;
        if (filteredVal !== '0) begin
            errors++; $display("FAIL reset_filteredVal: got %b want 0", filteredVal);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] vin[4];
        logic [W-1:0] vexp[4];
        int lat;
        vin  = '{6'b011100, 6'b010101, 6'b111111, 6'b000111};
        vexp = '{6'b011100, 6'b001010, 6'b011111, 6'b000111};
        for (int k = 0; k < 4; k++) begin
            send_word(vin[k], (k % 2) == 1);
            checks++;
            if (busy !== 1'b1 || bitReady !== 1'b0) begin
                errors++;
                $display("FAIL directed_filter_state[%0d]: busy=%b bitReady=%b want 1/0",
                         k, busy, bitReady);
            end
            wait_valid(lat);
            checks++;
            if (lat !== 2) begin
                errors++; $display("FAIL directed_latency[%0d]: got %0d want 2", k, lat);
            end
            checks++;
            if (filteredVal !== vexp[k]) begin
                errors++;
                $display("FAIL directed_value[%0d]: got %b want %b", k, filteredVal, vexp[k]);
            end
            consume();
            checks++;
            if (wordValid !== 1'b0 || bitReady !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL directed_release[%0d]: wordValid=%b bitReady=%b busy=%b want 0/1/0",
                         k, wordValid, bitReady, busy);
            end
            checks++;
            if (filteredVal !== vexp[k]) begin
                errors++;
                $display("FAIL directed_hold_in_collect[%0d]: got %b want %b",
                         k, filteredVal, vexp[k]);
            end
        end
    endtask

    // Stall cycles in HOLD with a bit already pending, then handshake and resume.
    task automatic run_handoff(input string name, input int stall);
        logic [W-1:0] w1, w2, e1;
        int lat;
        w1 = W'($urandom);
        w2 = W'($urandom);
        e1 = ref_filter(w1);
        send_word(w1, 1'b1);
        wait_valid(lat);
        bitIn = w2[0];
        bitValid = 1'b1;
        wordReady = 1'b0;
        for (int c = 0; c < stall; c++) begin
            tick();
            checks++;
            if (bitReady !== 1'b0 || wordValid !== 1'b1 || filteredVal !== e1) begin
                errors++;
                $display("FAIL %s_stall[%0d]: bitReady=%b wordValid=%b val=%b want 0/1/%b",
                         name, c, bitReady, wordValid, filteredVal, e1);
            end
        end
        checks++;
        if (filteredVal !== e1) begin
            errors++; $display("FAIL %s_value1: got %b want %b", name, filteredVal, e1);
        end
        wordReady = 1'b1;
        tick();
        wordReady = 1'b0;
        checks++;
        if (wordValid !== 1'b0 || bitReady !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_handshake: wordValid=%b bitReady=%b busy=%b want 0/1/0",
                     name, wordValid, bitReady, busy);
        end
        tick();
        bitValid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL %s_first_bit: busy=%b want 1", name, busy);
        end
        for (int i = 1; i < W; i++) send_bit(w2[i], 1'b0);
        wait_valid(lat);
        checks++;
        if (lat !== 2 || filteredVal !== ref_filter(w2)) begin
            errors++;
            $display("FAIL %s_value2: got %b lat %0d want %b lat 2",
                     name, filteredVal, lat, ref_filter(w2));
        end
        consume();
    endtask

    task automatic test_hold_stall();
        run_handoff("hold_stall", 5);
    endtask

    task automatic test_back_to_back();
        run_handoff("back_to_back", 0);
    endtask

    task automatic test_frame_restart();
        logic [W-1:0] w;
        int lat;
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_word(6'b111111, 1'b1);
        wait_valid(lat);
        checks++;
        if (lat !== 2 || filteredVal !== 6'b011111) begin
            errors++;
            $display("FAIL frame_restart: got %b lat %0d want 011111 lat 2", filteredVal, lat);
        end
        consume();
        // frameStart without bitValid must not restart the word.
        w = 6'b101101;
        send_bit(w[0], 1'b0);
        send_bit(w[1], 1'b0);
        frameStart = 1'b1;
        tick();
        frameStart = 1'b0;
        for (int i = 2; i < W; i++) send_bit(w[i], 1'b0);
        wait_valid(lat);
        checks++;
        if (lat !== 2 || filteredVal !== 6'b001110) begin
            errors++;
            $display("FAIL frame_ignore: got %b lat %0d want 001110 lat 2", filteredVal, lat);
        end
        consume();
    endtask

    task automatic test_reset_midword();
        int lat;
        int rises0;
        for (int i = 0; i < 4; i++) send_bit(1'($urandom), 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || bitReady !== 1'b1 || wordValid !== 1'b0 || filteredVal !== '0) begin
            errors++;
            $display("FAIL reset_mid_state: busy=%b bitReady=%b wordValid=%b val=%b want 0/1/0/0",
                     busy, bitReady, wordValid, filteredVal);
        end
        rises0 = wv_rises;
        send_word(6'b010101, 1'b0);
        wait_valid(lat);
        tick();
        checks++;
        if (lat !== 2 || filteredVal !== 6'b001010 || wv_rises - rises0 !== 1) begin
            errors++;
            $display("FAIL reset_mid_word: got %b lat %0d rises %0d want 001010 lat 2 rises 1",
                     filteredVal, lat, wv_rises - rises0);
        end
        consume();
        // Reset in HOLD wins over a simultaneous handshake and drops the word.
        send_word(6'b111111, 1'b1);
        wait_valid(lat);
        reset = 1'b1;
        wordReady = 1'b1;
        tick();
        reset = 1'b0;
        wordReady = 1'b0;
        checks++;
        if (wordValid !== 1'b0 || filteredVal !== '0 || bitReady !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_hold: wordValid=%b val=%b bitReady=%b want 0/0/1",
                     wordValid, filteredVal, bitReady);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] w, e;
        int lat, junk, stall;
        for (int k = 0; k < 40; k++) begin
            w = W'($urandom);
            e = ref_filter(w);
            junk = (($urandom % 2) == 0) ? 0 : int'($urandom_range(1, 4));
            for (int j = 0; j < junk; j++) send_bit(1'($urandom), 1'b0);
            for (int i = 0; i < W; i++) begin
                repeat ($urandom_range(0, 2)) begin
                    bitValid = 1'b0;
                    frameStart = 1'($urandom);
                    tick();
                end
                frameStart = 1'b0;
                send_bit(w[i], (i == 0) && (junk != 0 || ($urandom % 2) == 1));
            end
            wait_valid(lat);
            checks++;
            if (lat !== 2 || filteredVal !== e) begin
                errors++;
                $display("FAIL random[%0d]: in %b got %b lat %0d want %b lat 2",
                         k, w, filteredVal, lat, e);
            end
            stall = int'($urandom_range(0, 3));
            for (int c = 0; c < stall; c++) tick();
            checks++;
            if (wordValid !== 1'b1 || filteredVal !== e) begin
                errors++;
                $display("FAIL random_stall[%0d]: wordValid=%b val=%b want 1/%b",
                         k, wordValid, filteredVal, e);
            end
            consume();
        end
    endtask

    initial begin
        reset = 1'b0;
        bitIn = 1'b0;
        bitValid = 1'b0;
        frameStart = 1'b0;
        wordReady = 1'b0;
        test_reset();
        test_directed();
        test_hold_stall();
        test_frame_restart();
        test_reset_midword();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
